// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: opcode constants, sequencer state encoding and
// the opcode validity check used before launching a transmission.
package alu_defs;

    localparam int OPCODE_W = 6;

    localparam logic [OPCODE_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OPCODE_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OPCODE_W-1:0] OP_AND = 6'b100100;
    localparam logic [OPCODE_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OPCODE_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OPCODE_W-1:0] OP_NOR = 6'b100111;
    localparam logic [OPCODE_W-1:0] OP_SRA = 6'b000011;
    localparam logic [OPCODE_W-1:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } seq_state_t;

    function automatic logic is_valid_opcode(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Inter-byte timeout: counts oversampling ticks while enabled, saturating at
// the limit. expired also flags the cycle carrying the final tick.
module seq_timeout_counter #(
    parameter int TIMEOUT_TICKS = 640
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    input  logic tick,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_TICKS);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear || !enable) begin
            count_reg <= '0;
        end else if (tick && (count_reg != LIMIT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // A clear in the same cycle as the final tick suppresses expiry.
    assign expired = enable && !clear &&
                     ((count_reg == LIMIT) || (tick && (count_reg == LIMIT - 1'b1)));

endmodule

// File: rtl/uart_alu_sequencer.sv
// Frame sequencer between uart_rx, the ALU and uart_tx: gathers A, B and the
// opcode, checks the opcode, then hands the ALU result to the transmitter.
module uart_alu_sequencer
    import alu_defs::*;
#(
    parameter int DBIT          = 8,
    parameter int OP_W          = 6,
    parameter int TIMEOUT_TICKS = 640
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_tick,
    input  logic [DBIT-1:0] i_rx_data,
    input  logic            i_rx_done,
    input  logic [DBIT-1:0] i_alu_result,
    input  logic            i_tx_done,
    output logic [DBIT-1:0] o_data_a,
    output logic [DBIT-1:0] o_data_b,
    output logic [OP_W-1:0] o_opcode,
    output logic [DBIT-1:0] o_tx_data,
    output logic            o_tx_start,
    output logic            o_error,
    output logic            o_busy
);

    seq_state_t      state_reg, state_next;
    logic [DBIT-1:0] data_a_reg, data_a_next;
    logic [DBIT-1:0] data_b_reg, data_b_next;
    logic [OP_W-1:0] opcode_reg, opcode_next;
    logic [DBIT-1:0] tx_data_reg, tx_data_next;
    logic            tx_start_reg, tx_start_next;
    logic            error_reg, error_next;
    logic            timeout_en;
    logic            timeout_expired;

    assign timeout_en = (state_reg == ST_WAIT_B) || (state_reg == ST_WAIT_OP);

    // Every accepted byte restarts the window for the next one.
    seq_timeout_counter #(
        .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) u_timeout (
        .clk    (i_clk),
        .rst_n  (i_reset),
        .clear  (i_rx_done),
        .enable (timeout_en),
        .tick   (i_tick),
        .expired(timeout_expired)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg    <= ST_WAIT_A;
            data_a_reg   <= '0;
            data_b_reg   <= '0;
            opcode_reg   <= '0;
            tx_data_reg  <= '0;
            tx_start_reg <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            data_a_reg   <= data_a_next;
            data_b_reg   <= data_b_next;
            opcode_reg   <= opcode_next;
            tx_data_reg  <= tx_data_next;
            tx_start_reg <= tx_start_next;
            error_reg    <= error_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        data_a_next   = data_a_reg;
        data_b_next   = data_b_reg;
        opcode_next   = opcode_reg;
        tx_data_next  = tx_data_reg;
        tx_start_next = 1'b0;
        error_next    = 1'b0;
        case (state_reg)
            ST_WAIT_A: begin
                if (i_rx_done) begin
                    data_a_next = i_rx_data;
                    state_next  = ST_WAIT_B;
                end
            end
            ST_WAIT_B, ST_WAIT_OP: begin
                if (i_rx_done) begin
                    if (state_reg == ST_WAIT_B) begin
                        data_b_next = i_rx_data;
                        state_next  = ST_WAIT_OP;
                    end else begin
                        opcode_next = i_rx_data[OP_W-1:0];
                        state_next  = ST_EXEC;
                    end
                end else if (timeout_expired) begin
                    // Abandoned frame: drop the partial operands.
                    data_a_next = '0;
                    data_b_next = '0;
                    opcode_next = '0;
                    error_next  = 1'b1;
                    state_next  = ST_WAIT_A;
                end
            end
            ST_EXEC: begin
                if (is_valid_opcode(opcode_reg)) begin
                    tx_data_next  = i_alu_result;
                    tx_start_next = 1'b1;
                    state_next    = ST_SEND;
                end else begin
                    error_next = 1'b1;
                    state_next = ST_WAIT_A;
                end
            end
            ST_SEND: begin
                state_next = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (i_tx_done) begin
                    state_next = ST_WAIT_A;
                end
            end
            default: begin
                state_next = ST_WAIT_A;
            end
        endcase
    end

    assign o_data_a   = data_a_reg;
    assign o_data_b   = data_b_reg;
    assign o_opcode   = opcode_reg;
    assign o_tx_data  = tx_data_reg;
    assign o_tx_start = tx_start_reg;
    assign o_error    = error_reg;
    assign o_busy     = (state_reg != ST_WAIT_A);

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Directed bench for uart_alu_sequencer with a small behavioural ALU driving
// i_alu_result from the operands the sequencer presents.
module tb_uart_alu_sequencer;

    localparam int DBIT = 8;
    localparam int OP_W = 6;
    localparam int TIMEOUT_TICKS = 640;

    logic            i_clk = 1'b0;
    logic            i_reset = 1'b0;
    logic            i_tick = 1'b0;
    logic [DBIT-1:0] i_rx_data = '0;
    logic            i_rx_done = 1'b0;
    logic [DBIT-1:0] i_alu_result;
    logic            i_tx_done = 1'b0;
    logic [DBIT-1:0] o_data_a;
    logic [DBIT-1:0] o_data_b;
    logic [OP_W-1:0] o_opcode;
    logic [DBIT-1:0] o_tx_data;
    logic            o_tx_start;
    logic            o_error;
    logic            o_busy;

    int tests = 0;
    int fails = 0;

    uart_alu_sequencer #(
        .DBIT(DBIT), .OP_W(OP_W), .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_tick(i_tick),
        .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
        .i_alu_result(i_alu_result), .i_tx_done(i_tx_done),
        .o_data_a(o_data_a), .o_data_b(o_data_b), .o_opcode(o_opcode),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
        .o_error(o_error), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    always_comb begin
        case (o_opcode)
            6'b100000: i_alu_result = o_data_a + o_data_b;
            6'b100010: i_alu_result = o_data_a - o_data_b;
            6'b100100: i_alu_result = o_data_a & o_data_b;
            6'b100101: i_alu_result = o_data_a | o_data_b;
            6'b100110: i_alu_result = o_data_a ^ o_data_b;
            6'b100111: i_alu_result = ~(o_data_a | o_data_b);
            6'b000011: i_alu_result = $signed(o_data_a) >>> o_data_b;
            6'b000010: i_alu_result = o_data_a >> o_data_b;
            default:   i_alu_result = '0;
        endcase
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        step();
        i_rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        step();
        step();
        chk("rst_data_a", 32'(o_data_a), 32'h00);
        chk("rst_tx_data", 32'(o_tx_data), 32'h00);
        chk("rst_tx_start", 32'(o_tx_start), 32'h0);
        chk("rst_error", 32'(o_error), 32'h0);
        chk("rst_busy", 32'(o_busy), 32'h0);
        i_reset = 1'b1;
        step();

        // ADD frame: 5 + 3
        send_byte(8'h05);
        chk("add_busy_b", 32'(o_busy), 32'h1);
        send_byte(8'h03);
        send_byte(8'h20);
        chk("add_data_a", 32'(o_data_a), 32'h05);
        chk("add_data_b", 32'(o_data_b), 32'h03);
        chk("add_opcode", 32'(o_opcode), 32'h20);
        chk("add_start_exec", 32'(o_tx_start), 32'h0);
        step();
        chk("add_start", 32'(o_tx_start), 32'h1);
        chk("add_tx_data", 32'(o_tx_data), 32'h08);
        chk("add_no_error", 32'(o_error), 32'h0);
        step();
        chk("add_start_drop", 32'(o_tx_start), 32'h0);
        chk("add_busy_wait_tx", 32'(o_busy), 32'h1);
        pulse_tx_done();
        chk("add_busy_done", 32'(o_busy), 32'h0);

        // Invalid opcode frame
        send_byte(8'h10);
        send_byte(8'h01);
        send_byte(8'h3F);
        chk("inv_opcode", 32'(o_opcode), 32'h3F);
        chk("inv_err_early", 32'(o_error), 32'h0);
        step();
        chk("inv_error", 32'(o_error), 32'h1);
        chk("inv_no_start", 32'(o_tx_start), 32'h0);
        chk("inv_busy", 32'(o_busy), 32'h0);
        chk("inv_keep_a", 32'(o_data_a), 32'h10);
        step();
        chk("inv_error_drop", 32'(o_error), 32'h0);
        chk("inv_tx_data_kept", 32'(o_tx_data), 32'h08);

        // Timeout after operand A
        send_byte(8'h07);
        i_tick = 1'b1;
        for (int i = 1; i < TIMEOUT_TICKS; i++) begin
            step();
            chk("to_quiet", 32'(o_error), 32'h0);
        end
        step();
        i_tick = 1'b0;
        chk("to_error", 32'(o_error), 32'h1);
        chk("to_busy", 32'(o_busy), 32'h0);
        chk("to_clear_a", 32'(o_data_a), 32'h00);
        chk("to_clear_b", 32'(o_data_b), 32'h00);
        chk("to_clear_op", 32'(o_opcode), 32'h00);
        step();
        chk("to_error_drop", 32'(o_error), 32'h0);

        // Byte on the final tick wins over the timeout
        send_byte(8'h07);
        i_tick = 1'b1;
        for (int i = 1; i < TIMEOUT_TICKS; i++) step();
        i_rx_data = 8'h09;
        i_rx_done = 1'b1;
        step();
        i_rx_done = 1'b0;
        i_tick = 1'b0;
        chk("race_no_error", 32'(o_error), 32'h0);
        chk("race_data_b", 32'(o_data_b), 32'h09);
        chk("race_busy", 32'(o_busy), 32'h1);
        step();
        chk("race_no_error2", 32'(o_error), 32'h0);
        send_byte(8'h25);
        step();
        chk("or_start", 32'(o_tx_start), 32'h1);
        chk("or_tx_data", 32'(o_tx_data), 32'h0F);
        step();

        // Extra byte while waiting for tx is dropped
        send_byte(8'hAA);
        chk("drop_busy", 32'(o_busy), 32'h1);
        chk("drop_keep_a", 32'(o_data_a), 32'h07);
        chk("drop_no_start", 32'(o_tx_start), 32'h0);
        pulse_tx_done();
        chk("drop_idle", 32'(o_busy), 32'h0);
        send_byte(8'h02);
        send_byte(8'h02);
        send_byte(8'h22);
        step();
        chk("sub_start", 32'(o_tx_start), 32'h1);
        chk("sub_tx_data", 32'(o_tx_data), 32'h00);
        chk("sub_data_a", 32'(o_data_a), 32'h02);
        step();
        pulse_tx_done();

        // Reset during the start cycle
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h20);
        step();
        chk("mid_start", 32'(o_tx_start), 32'h1);
        #1;
        i_reset = 1'b0;
        #1;
        chk("mid_rst_start", 32'(o_tx_start), 32'h0);
        chk("mid_rst_tx_data", 32'(o_tx_data), 32'h00);
        chk("mid_rst_data_a", 32'(o_data_a), 32'h00);
        chk("mid_rst_opcode", 32'(o_opcode), 32'h00);
        chk("mid_rst_busy", 32'(o_busy), 32'h0);
        chk("mid_rst_error", 32'(o_error), 32'h0);
        i_reset = 1'b1;
        step();
        chk("post_rst_start", 32'(o_tx_start), 32'h0);
        chk("post_rst_busy", 32'(o_busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_alu_sequencer.md
Name: uart_alu_sequencer

Overview:
Control FSM between uart_rx, the ALU and uart_tx in the UART/ALU system.
- Collects three received bytes (operand A, operand B, opcode), presents them to the ALU, validates the opcode, and launches transmission of the result byte.
- Guards partial frames with an inter-byte timeout counted in baudrate_generator oversampling ticks.

Parameters:
- DBIT, 8, data/operand width in bits.
- OP_W, 6, opcode width; the low OP_W bits of the opcode byte are used.
- TIMEOUT_TICKS, 640, o_tick pulses allowed between bytes of one frame (4 UART frames at SAMPLING=16, 10 bits per frame).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_tick  in  1  oversampling tick from baudrate_generator.
- i_rx_data  in  DBIT  byte from uart_rx.
- i_rx_done  in  1  one-cycle pulse, i_rx_data valid.
- i_alu_result  in  DBIT  combinational ALU result.
- i_tx_done  in  1  one-cycle pulse, uart_tx finished its frame.
- o_data_a  out  DBIT  operand A to ALU.
- o_data_b  out  DBIT  operand B to ALU.
- o_opcode  out  OP_W  opcode to ALU.
- o_tx_data  out  DBIT  byte to uart_tx.
- o_tx_start  out  1  one-cycle start pulse to uart_tx.
- o_error  out  1  one-cycle pulse on timeout or invalid opcode.
- o_busy  out  1  high in every state except WAIT_A.

Behaviour:
- Reset (asynchronous, i_reset=0):
  - State=WAIT_A; timeout counter=0.
  - All data outputs=0; o_tx_start=0, o_error=0, o_busy=0.
- States and transitions:
  - WAIT_A: on i_rx_done, latch o_data_a, clear counter, go to WAIT_B.
  - WAIT_B: on i_rx_done, latch o_data_b, clear counter, go to WAIT_OP.
  - WAIT_OP: on i_rx_done, latch o_opcode=i_rx_data[OP_W-1:0], go to EXEC.
  - EXEC (1 cycle):
    - Valid opcode: latch o_tx_data=i_alu_result, go to SEND.
    - Invalid opcode: pulse o_error, go to WAIT_A; operands are kept.
  - SEND (1 cycle): o_tx_start=1, go to WAIT_TX.
  - WAIT_TX: on i_tx_done, go to WAIT_A.
- Latency:
  - Opcode i_rx_done sampled at edge n: EXEC in cycle n+1, o_tx_start high exactly in cycle n+2.
  - o_tx_data is stable from n+2 until the next EXEC.
- Timeout:
  - Active only in WAIT_B and WAIT_OP.
  - Counter increments on i_tick and clears on entry to each of these states.
  - If the counter reaches TIMEOUT_TICKS with no i_rx_done: pulse o_error, go to WAIT_A, clear o_data_a, o_data_b and o_opcode.
  - If i_rx_done and the final tick occur in the same cycle, i_rx_done wins: no error.
  - Counter width is $clog2(TIMEOUT_TICKS+1) and saturates (never wraps).
- i_rx_done in EXEC, SEND or WAIT_TX: byte dropped, no state change (rx is ignored while a result is in flight).
- i_tx_done outside WAIT_TX: ignored.
- i_tick is ignored in states where the timeout is inactive.
- Reset mid-operation: immediate return to reset values. A pending o_tx_start or o_error is cancelled.
- o_tx_start and o_error are registered, never combinational, and never asserted in the same cycle.

Decomposition:
- Shared package/header alu_defs holds:
  - opcode constants: ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, NOR 6'b100111, SRA 6'b000011, SRL 6'b000010;
  - state encodings;
  - an is_valid_opcode function.
- One natural sub-module: seq_timeout_counter, the tick-driven saturating counter with clear, enable and expired outputs.

Test Plan:
- Bytes 0x05, 0x03, 0x20 via i_rx_done, ALU model adds → o_data_a=0x05, o_data_b=0x03, o_opcode=0x20; o_tx_start one cycle, 2 cycles after the third i_rx_done, with o_tx_data=0x08; o_busy=1 until i_tx_done.
- Bytes 0x10, 0x01, 0x3F (invalid opcode) → o_error pulse 1 cycle after the third byte; o_tx_start never asserted; o_busy=0 next cycle.
- Byte 0x07, then 640 i_tick pulses with no rx → o_error pulse on the 640th tick; state WAIT_A; o_data_a=0.
- Byte 0x07, then 639 ticks, then i_rx_done coinciding with tick 640 → no error; o_data_b latched.
- Extra i_rx_done while in WAIT_TX → ignored; the next frame 0x02, 0x02, 0x22 (SUB) after i_tx_done yields o_tx_data=0x00.
- i_reset=0 asserted in cycle n+2 of a frame (the o_tx_start cycle) → o_tx_start=0 immediately and all outputs at reset values.
